full_subtractor: RTL and testbench

FULL_SUBTRACTOR -- requirements
Module: full_subtractor

---
 rtl/full_subtractor_pkg.sv | 25 ++
 rtl/full_subtractor_fs_bit.sv | 13 +
 rtl/full_subtractor.sv | 66 ++++++
 tb/tb_full_subtractor.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/full_subtractor_pkg.sv
// rtl/full_subtractor_pkg.sv - shared constants and reference model for full_subtractor
package full_subtractor_pkg;

    localparam int WIDTH_DEFAULT = 1;
    localparam int WIDTH_MAX     = 64;

    // Returns {borrow, diff} with borrow at bit position width and diff in bits width-1:0.
    function automatic logic [WIDTH_MAX:0] ref_sub(
        input logic [WIDTH_MAX-1:0] a,
        input logic [WIDTH_MAX-1:0] b,
        input logic                 c,
        input int                   width = WIDTH_DEFAULT
    );
        logic [WIDTH_MAX-1:0] mask;
        logic [WIDTH_MAX:0]   r;
        logic [WIDTH_MAX:0]   res;
        mask = (width >= WIDTH_MAX) ? '1 : ((64'd1 << width) - 64'd1);
        r    = {1'b0, a & mask} - {1'b0, b & mask} - {{WIDTH_MAX{1'b0}}, c};
        // Any negative result sign-extends through bit width of the 65-bit difference.
        res  = {1'b0, r[WIDTH_MAX-1:0] & mask};
        res[width[6:0]] = r[width[6:0]];
        return res;
    endfunction

endpackage

// File: rtl/full_subtractor_fs_bit.sv
// rtl/full_subtractor_fs_bit.sv - combinational one-bit full subtractor cell
module fs_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - registered ripple-borrow subtractor; FULL_SUBTRACTOR_OVF_EN adds the ovf output
module full_subtractor
    import full_subtractor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic             out_valid,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef FULL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH:0]   bchain;
    logic [WIDTH-1:0] diff_next;

    assign bchain[0] = c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fs_bit u_bit (
            .a    (a[i]),
            .b    (b[i]),
            .bin  (bchain[i]),
            .d    (diff_next[i]),
            .bout (bchain[i+1])
        );
    end

    // Data registers load only on in_valid so idle (possibly X) operands never reach state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                diff   <= diff_next;
                borrow <= bchain[WIDTH];
            end
        end
    end

`ifdef FULL_SUBTRACTOR_OVF_EN
    logic ovf_next;

    assign ovf_next = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ diff_next[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (in_valid) begin
            ovf <= ovf_next;
        end
    end
`endif

endmodule

// File: tb/tb_full_subtractor.sv
// tb/tb_full_subtractor.sv - scoreboard bench driving WIDTH=1 and WIDTH=8 instances
module tb_full_subtractor;
    import full_subtractor_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iv1, a1, b1, c1, ov1, d1, bo1;
    logic       iv8, c8, ov8, bo8;
    logic [7:0] a8, b8, d8;
`ifdef FULL_SUBTRACTOR_OVF_EN
    logic       ovf1, ovf8;
`endif

    always #5 clk = ~clk;

    full_subtractor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1), .c(c1),
        .out_valid(ov1), .diff(d1), .borrow(bo1)
`ifdef FULL_SUBTRACTOR_OVF_EN
        , .ovf(ovf1)
`endif
    );

    full_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .a(a8), .b(b8), .c(c8),
        .out_valid(ov8), .diff(d8), .borrow(bo8)
`ifdef FULL_SUBTRACTOR_OVF_EN
        , .ovf(ovf8)
`endif
    );

    typedef struct {
        logic [7:0] diff;
        logic       borrow;
        logic       ovf;
    } exp_t;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q1[$];
    exp_t q8[$];
    exp_t hold1, hold8;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic c, input int w);
        logic [64:0] r;
        exp_t        e;
        r        = ref_sub({56'd0, a}, {56'd0, b}, c, w);
        e.diff   = (w == 1) ? {7'd0, r[0]} : r[7:0];
        e.borrow = r[w];
        e.ovf    = (a[w-1] ^ b[w-1]) & (a[w-1] ^ e.diff[w-1]);
        return e;
    endfunction

    task automatic clear_model();
        hold1 = '{8'd0, 1'b0, 1'b0};
        hold8 = '{8'd0, 1'b0, 1'b0};
        q1.delete();
        q8.delete();
    endtask

    task automatic check_outputs(input string tag, input logic v1, input logic v8);
        check({tag, " ov1"}, {63'd0, ov1}, {63'd0, v1});
        check({tag, " ov8"}, {63'd0, ov8}, {63'd0, v8});
        if (v1 && q1.size() > 0) hold1 = q1.pop_front();
        if (v8 && q8.size() > 0) hold8 = q8.pop_front();
        check({tag, " d1"},  {63'd0, d1},  {56'd0, hold1.diff});
        check({tag, " bo1"}, {63'd0, bo1}, {63'd0, hold1.borrow});
        check({tag, " d8"},  {56'd0, d8},  {56'd0, hold8.diff});
        check({tag, " bo8"}, {63'd0, bo8}, {63'd0, hold8.borrow});
`ifdef FULL_SUBTRACTOR_OVF_EN
        check({tag, " ovf1"}, {63'd0, ovf1}, {63'd0, hold1.ovf});
        check({tag, " ovf8"}, {63'd0, ovf8}, {63'd0, hold8.ovf});
`endif
    endtask

    // Drive one cycle on both instances, then check what that edge registered.
    task automatic cycle(input string tag, input logic v1, input logic [2:0] abc1,
                         input logic v8, input logic [7:0] a, input logic [7:0] b, input logic c);
        iv1 = v1;
        {a1, b1, c1} = abc1;
        iv8 = v8;
        a8  = a;
        b8  = b;
        c8  = c;
        if (v1) q1.push_back(model({7'd0, abc1[2]}, {7'd0, abc1[1]}, abc1[0], 1));
        if (v8) q8.push_back(model(a, b, c, 8));
        @(posedge clk);
        #1;
        check_outputs(tag, v1, v8);
    endtask

    initial begin
        rst_n = 1'b0;
        iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        iv8 = 1'b0; a8 = 8'd0; b8 = 8'd0; c8 = 1'b0;
        clear_model();
        #1;
        check_outputs("reset", 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            cycle("truth", 1'b1, i[2:0], 1'b0, 8'd0, 8'd0, 1'b0);
        end
        cycle("idle1", 1'b0, 3'b000, 1'b0, 8'd0, 8'd0, 1'b0);

        cycle("w8_a", 1'b0, 3'b000, 1'b1, 8'h05, 8'h03, 1'b1);
        cycle("w8_b", 1'b0, 3'b000, 1'b1, 8'h03, 8'h05, 1'b0);
        cycle("wrap", 1'b0, 3'b000, 1'b1, 8'h00, 8'hFF, 1'b1);
        cycle("ovf_a", 1'b0, 3'b000, 1'b1, 8'h80, 8'h01, 1'b0);
        cycle("ovf_b", 1'b0, 3'b000, 1'b1, 8'h10, 8'h01, 1'b0);

        cycle("gap1", 1'b0, 3'b000, 1'b1, 8'h42, 8'h11, 1'b0);
        cycle("gap0x", 1'b0, 3'bxxx, 1'b0, 8'hxx, 8'hxx, 1'bx);
        cycle("gap2", 1'b0, 3'b000, 1'b1, 8'h11, 8'h42, 1'b1);

        for (int i = 0; i < 24; i++) begin
            cycle("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        cycle("pre_rst", 1'b1, 3'b001, 1'b1, 8'h5A, 8'h3C, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        clear_model();
        check_outputs("async_rst", 1'b0, 1'b0);
        iv8 = 1'b1; a8 = 8'h33; b8 = 8'h11; c8 = 1'b0;
        iv1 = 1'b1; {a1, b1, c1} = 3'b100;
        @(posedge clk);
        #1;
        check_outputs("in_rst", 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;
        cycle("post_rst", 1'b1, 3'b010, 1'b1, 8'h20, 8'h01, 1'b0);
        cycle("post_idle", 1'b0, 3'b000, 1'b0, 8'd0, 8'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
